// File: rtl/sap2_tstate_sequencer.sv
// SAP-2 variable-length T-state sequencer: one-hot T1..Tn with per-opcode length,
// HLT freeze, memory stall and unknown-opcode flagging. State changes on the falling edge.
module sap2_tstate_sequencer #(
  parameter int unsigned pNumStates   = 18,
  parameter int unsigned pFetchStates = 3,
  parameter int unsigned pDefaultLen  = 4
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic [7:0]            iOpcode,
  input  logic                  iFlagZ,
  input  logic                  iFlagS,
  input  logic                  iStall,
  output logic [pNumStates-1:0] oTState,
  output logic [pNumStates-1:0] oTStateBar,
  output logic [4:0]            oLength,
  output logic                  oLastState,
  output logic                  oHalted,
  output logic                  oIllegal
);

  localparam int unsigned LenW = 5;
  localparam int unsigned IdxW = $clog2(pNumStates + 1);
  localparam logic [pNumStates-1:0] TFirst = {{(pNumStates-1){1'b0}}, 1'b1};
  localparam logic [7:0] OpHlt = 8'h76;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } mode_t;

  mode_t                  mode_q, mode_d;
  logic [pNumStates-1:0]  tstate_q, tstate_d;
  logic [LenW-1:0]        len_q, len_d;
  logic                   hlt_q, hlt_d;
  logic                   illegal_q, illegal_d;
  logic [IdxW-1:0]        idx;
  logic [LenW-1:0]        dec_len;
  logic                   dec_legal;
  logic                   at_final;

  // Opcode + flags -> {legal, length}; unknown opcodes fall back to the default length.
  function automatic logic [LenW:0] decode(input logic [7:0] op, input logic z, input logic s);
    logic [LenW-1:0] len;
    logic            legal;
    legal = 1'b1;
    len   = LenW'(pDefaultLen);
    case (op)
      8'h00, 8'h2F, 8'h3C, 8'h3D, 8'h17, 8'h1F,
      8'h78, 8'h80, 8'h81, 8'h90, 8'hA0, 8'hB0: len = LenW'(4);
      8'h76:                                    len = LenW'(5);
      8'h3E, 8'hE6, 8'hF6, 8'hEE:               len = LenW'(7);
      8'hC3, 8'hC9, 8'hDB, 8'hD3:               len = LenW'(10);
      8'h3A, 8'h32:                             len = LenW'(13);
      8'hCD:                                    len = LenW'(18);
      8'hCA:                                    len = z  ? LenW'(10) : LenW'(7);
      8'hC2:                                    len = !z ? LenW'(10) : LenW'(7);
      8'hFA:                                    len = s  ? LenW'(10) : LenW'(7);
      default:                                  legal = 1'b0;
    endcase
    if (int'(len) > int'(pNumStates)) len = LenW'(pNumStates);
    return {legal, len};
  endfunction

  assign {dec_legal, dec_len} = decode(iOpcode, iFlagZ, iFlagS);

  // One-hot to 1-based index (0 = idle).
  always_comb begin
    idx = '0;
    for (int unsigned k = 0; k < pNumStates; k++) begin
      if (tstate_q[k]) idx = IdxW'(k + 1);
    end
  end

  assign at_final = ((idx == IdxW'(len_q)) && (idx > IdxW'(pFetchStates)))
                  || tstate_q[pNumStates-1];

  // Next-state logic; oIllegal is a pulse so it defaults low on every edge.
  always_comb begin
    mode_d    = mode_q;
    tstate_d  = tstate_q;
    len_d     = len_q;
    hlt_d     = hlt_q;
    illegal_d = 1'b0;
    case (mode_q)
      ST_IDLE: begin
        tstate_d = TFirst;
        mode_d   = ST_RUN;
      end
      ST_RUN: begin
        if (!iStall) begin
          if (at_final) begin
            if (hlt_q) mode_d = ST_HALT;
            else       tstate_d = TFirst;
          end else begin
            tstate_d = tstate_q << 1;
            if (idx == IdxW'(pFetchStates)) begin
              len_d     = dec_len;
              illegal_d = !dec_legal;
              hlt_d     = (iOpcode == OpHlt);
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(negedge iClk or posedge iReset) begin
    if (iReset) begin
      mode_q    <= ST_IDLE;
      tstate_q  <= '0;
      len_q     <= '0;
      hlt_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      tstate_q  <= tstate_d;
      len_q     <= len_d;
      hlt_q     <= hlt_d;
      illegal_q <= illegal_d;
    end
  end

  assign oTState    = tstate_q;
  assign oTStateBar = ~tstate_q;
  assign oLength    = len_q;
  assign oHalted    = (mode_q == ST_HALT);
  assign oIllegal   = illegal_q;
  assign oLastState = (idx == IdxW'(len_q)) && (idx > IdxW'(pFetchStates)) && (mode_q != ST_HALT);

endmodule

// File: tb/tb_sap2_tstate_sequencer.sv
// Bench for sap2_tstate_sequencer: table of instructions expanded into per-cycle
// expectations on a scoreboard queue, plus hand sequences for stall, reset and HLT.
module tb_sap2_tstate_sequencer;

  localparam int NS = 18;

  logic          iClk, iReset, iFlagZ, iFlagS, iStall;
  logic [7:0]    iOpcode;
  logic [NS-1:0] oTState, oTStateBar;
  logic [4:0]    oLength;
  logic          oLastState, oHalted, oIllegal;

  sap2_tstate_sequencer #(.pNumStates(NS), .pFetchStates(3), .pDefaultLen(4)) dut (
    .iClk(iClk), .iReset(iReset), .iOpcode(iOpcode), .iFlagZ(iFlagZ), .iFlagS(iFlagS),
    .iStall(iStall), .oTState(oTState), .oTStateBar(oTStateBar), .oLength(oLength),
    .oLastState(oLastState), .oHalted(oHalted), .oIllegal(oIllegal)
  );

  typedef struct {
    int         idx;
    logic [4:0] len;
    logic       last;
    logic       ill;
    logic       halt;
  } exp_t;

  typedef struct {
    logic [7:0] op;
    logic       z;
    logic       s;
    int         len;
    logic       ill;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[18];
  int         tests, failed;
  logic [4:0] prev_len;

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic exp_t mk(input int idx, input logic [4:0] len, input logic last,
                              input logic ill, input logic halt);
    exp_t e;
    e.idx = idx; e.len = len; e.last = last; e.ill = ill; e.halt = halt;
    return e;
  endfunction

  function automatic logic [NS-1:0] onehot(input int i);
    logic [NS-1:0] v;
    v = '0;
    if (i > 0) v[i-1] = 1'b1;
    return v;
  endfunction

  task automatic check_front(input string tag);
    exp_t          e;
    logic [NS-1:0] ev;
    tests++;
    if (sb.size() == 0) begin
      failed++;
      $display("FAIL %s: scoreboard empty, got T=%h required an expectation", tag, oTState);
      return;
    end
    e  = sb.pop_front();
    ev = onehot(e.idx);
    if (oTState !== ev || oTStateBar !== ~ev || oLength !== e.len || oLastState !== e.last
        || oIllegal !== e.ill || oHalted !== e.halt) begin
      failed++;
      $display("FAIL %s: got T=%h bar=%h len=%0d last=%b ill=%b halt=%b, required T=%h bar=%h len=%0d last=%b ill=%b halt=%b",
               tag, oTState, oTStateBar, oLength, oLastState, oIllegal, oHalted,
               ev, ~ev, e.len, e.last, e.ill, e.halt);
    end
  endtask

  // Inputs are set before the call; expectation is for the state after the next falling edge.
  task automatic tick(input exp_t e, input string tag);
    sb.push_back(e);
    @(negedge iClk);
    @(posedge iClk);
    check_front(tag);
  endtask

  task automatic expect_now(input exp_t e, input string tag);
    sb.push_back(e);
    check_front(tag);
  endtask

  // DUT is at T1; run one instruction through to the following T1.
  task automatic run_instr(input vec_t v);
    string t;
    iOpcode = v.op; iFlagZ = v.z; iFlagS = v.s; iStall = 1'b0;
    t = $sformatf("op%02h", v.op);
    tick(mk(2, prev_len, 1'b0, 1'b0, 1'b0), {t, "_T2"});
    tick(mk(3, prev_len, 1'b0, 1'b0, 1'b0), {t, "_T3"});
    for (int k = 4; k <= v.len; k++)
      tick(mk(k, 5'(v.len), k == v.len, (k == 4) && v.ill, 1'b0), $sformatf("%s_T%0d", t, k));
    tick(mk(1, 5'(v.len), 1'b0, 1'b0, 1'b0), {t, "_wrap"});
    prev_len = 5'(v.len);
  endtask

  initial begin
    tests = 0; failed = 0;
    vecs[0]  = '{8'h00, 1'b0, 1'b0,  4, 1'b0};
    vecs[1]  = '{8'h2F, 1'b0, 1'b0,  4, 1'b0};
    vecs[2]  = '{8'h3E, 1'b0, 1'b0,  7, 1'b0};
    vecs[3]  = '{8'hC3, 1'b0, 1'b0, 10, 1'b0};
    vecs[4]  = '{8'h3A, 1'b0, 1'b0, 13, 1'b0};
    vecs[5]  = '{8'hCD, 1'b0, 1'b0, 18, 1'b0};
    vecs[6]  = '{8'hCA, 1'b1, 1'b0, 10, 1'b0};
    vecs[7]  = '{8'hCA, 1'b0, 1'b0,  7, 1'b0};
    vecs[8]  = '{8'hC2, 1'b0, 1'b0, 10, 1'b0};
    vecs[9]  = '{8'hC2, 1'b1, 1'b0,  7, 1'b0};
    vecs[10] = '{8'hFA, 1'b0, 1'b1, 10, 1'b0};
    vecs[11] = '{8'hFA, 1'b0, 1'b0,  7, 1'b0};
    vecs[12] = '{8'h81, 1'b0, 1'b0,  4, 1'b0};
    vecs[13] = '{8'hD3, 1'b0, 1'b0, 10, 1'b0};
    vecs[14] = '{8'hFF, 1'b0, 1'b0,  4, 1'b1};
    vecs[15] = '{8'h32, 1'b1, 1'b1, 13, 1'b0};
    vecs[16] = '{8'h01, 1'b0, 1'b0,  4, 1'b1};
    vecs[17] = '{8'hEE, 1'b0, 1'b0,  7, 1'b0};

    iReset = 1'b1; iOpcode = 8'h00; iFlagZ = 1'b0; iFlagS = 1'b0; iStall = 1'b0;
    #2;
    expect_now(mk(0, 5'd0, 1'b0, 1'b0, 1'b0), "reset");
    @(posedge iClk);
    iReset = 1'b0;
    prev_len = 5'd0;
    tick(mk(1, 5'd0, 1'b0, 1'b0, 1'b0), "first_T1");

    foreach (vecs[i]) run_instr(vecs[i]);

    // Stall held at T2 for three edges, then a stall across T3->T4 with the opcode changing.
    iOpcode = 8'h00; iStall = 1'b0;
    tick(mk(2, prev_len, 1'b0, 1'b0, 1'b0), "stall_T2");
    iStall = 1'b1;
    for (int k = 0; k < 3; k++) tick(mk(2, prev_len, 1'b0, 1'b0, 1'b0), "stall_hold_T2");
    iStall = 1'b0;
    tick(mk(3, prev_len, 1'b0, 1'b0, 1'b0), "stall_T3");
    iStall = 1'b1;
    for (int k = 0; k < 2; k++) tick(mk(3, prev_len, 1'b0, 1'b0, 1'b0), "stall_hold_T3");
    iOpcode = 8'h3E; iStall = 1'b0;
    for (int k = 4; k <= 7; k++) tick(mk(k, 5'd7, k == 7, 1'b0, 1'b0), $sformatf("stall_mvi_T%0d", k));
    iStall = 1'b1;
    for (int k = 0; k < 2; k++) tick(mk(7, 5'd7, 1'b1, 1'b0, 1'b0), "stall_hold_final");
    iStall = 1'b0;
    tick(mk(1, 5'd7, 1'b0, 1'b0, 1'b0), "stall_wrap");
    prev_len = 5'd7;

    // LDA interrupted by reset between edges during T9.
    iOpcode = 8'h3A;
    tick(mk(2, prev_len, 1'b0, 1'b0, 1'b0), "lda_T2");
    tick(mk(3, prev_len, 1'b0, 1'b0, 1'b0), "lda_T3");
    for (int k = 4; k <= 9; k++) tick(mk(k, 5'd13, 1'b0, 1'b0, 1'b0), $sformatf("lda_T%0d", k));
    #2 iReset = 1'b1;
    #1 expect_now(mk(0, 5'd0, 1'b0, 1'b0, 1'b0), "lda_async_reset");
    @(posedge iClk);
    iReset = 1'b0;
    prev_len = 5'd0;
    tick(mk(1, 5'd0, 1'b0, 1'b0, 1'b0), "post_reset_T1");

    // HLT freezes at T5 regardless of stall; only reset releases it.
    iOpcode = 8'h76;
    tick(mk(2, 5'd0, 1'b0, 1'b0, 1'b0), "hlt_T2");
    tick(mk(3, 5'd0, 1'b0, 1'b0, 1'b0), "hlt_T3");
    tick(mk(4, 5'd5, 1'b0, 1'b0, 1'b0), "hlt_T4");
    tick(mk(5, 5'd5, 1'b1, 1'b0, 1'b0), "hlt_T5");
    tick(mk(5, 5'd5, 1'b0, 1'b0, 1'b1), "hlt_freeze");
    for (int k = 0; k < 20; k++) begin
      iStall = k[0];
      tick(mk(5, 5'd5, 1'b0, 1'b0, 1'b1), $sformatf("hlt_hold%0d", k));
    end
    iStall = 1'b0;
    #2 iReset = 1'b1;
    #1 expect_now(mk(0, 5'd0, 1'b0, 1'b0, 1'b0), "hlt_reset");
    @(posedge iClk);
    iReset = 1'b0;
    iOpcode = 8'h00;
    tick(mk(1, 5'd0, 1'b0, 1'b0, 1'b0), "hlt_restart_T1");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
